// File: rtl/msrv32_pipe_skid_stage.sv
// msrv32_pipe_skid_stage: generic inter-stage pipeline register with a 2-entry skid buffer.
// Carries an opaque payload and a target/iadder field with valid/ready handshakes on both
// sides. flush_in kills every held entry. The stored target has bit 0 cleared for taken
// branches when CLEAR_LSB is set.
// Optional feature: define MSRV32_PIPE_PERF_EN to build the stall and bubble counters.
// Without that macro both counter outputs are tied to zero.
module msrv32_pipe_skid_stage #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned TGT_W     = 32,
  parameter bit          CLEAR_LSB = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 flush_in,
  input  logic                 s_valid_in,
  output logic                 s_ready_out,
  input  logic [PAYLOAD_W-1:0] s_payload_in,
  input  logic [TGT_W-1:0]     s_target_in,
  input  logic                 s_branch_taken_in,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic [PAYLOAD_W-1:0] m_payload_out,
  output logic [TGT_W-1:0]     m_target_out,
  output logic [1:0]           occupancy_out,
  output logic [CNT_W-1:0]     stall_cnt_out,
  output logic [CNT_W-1:0]     bubble_cnt_out
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q;
  logic                 main_valid_q;
  logic                 skid_valid_q;
  logic [1:0]           occ_q;
  logic [PAYLOAD_W-1:0] main_payload_q;
  logic [PAYLOAD_W-1:0] skid_payload_q;
  logic [TGT_W-1:0]     main_target_q;
  logic [TGT_W-1:0]     skid_target_q;
  logic [TGT_W-1:0]     in_target;
  logic                 accept;
  logic                 pop;

  // Ready depends only on the skid slot being free, so upstream never sees a comb path
  // from m_ready_in.
  assign s_ready_out = ~skid_valid_q;
  assign accept      = s_valid_in & s_ready_out;
  assign pop         = main_valid_q & m_ready_in;

  assign m_valid_out   = main_valid_q;
  assign m_payload_out = main_payload_q;
  assign m_target_out  = main_target_q;
  assign occupancy_out = occ_q;

  // Target transform applied at capture: taken branches get their LSB cleared.
  always_comb begin
    in_target = s_target_in;
    if (CLEAR_LSB && s_branch_taken_in) begin
      in_target[0] = 1'b0;
    end
  end

  // Occupancy FSM with registered valid/occupancy outputs and the two data slots.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= StEmpty;
      main_valid_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      occ_q          <= 2'd0;
      main_payload_q <= '0;
      skid_payload_q <= '0;
      main_target_q  <= '0;
      skid_target_q  <= '0;
    end else if (flush_in) begin
      // Data slots are left as-is; only the valids matter once killed.
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q        <= StOne;
            main_valid_q   <= 1'b1;
            occ_q          <= 2'd1;
            main_payload_q <= s_payload_in;
            main_target_q  <= in_target;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_payload_q <= s_payload_in;
            main_target_q  <= in_target;
          end else if (accept) begin
            state_q        <= StFull;
            skid_valid_q   <= 1'b1;
            occ_q          <= 2'd2;
            skid_payload_q <= s_payload_in;
            skid_target_q  <= in_target;
          end else if (pop) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            occ_q        <= 2'd0;
          end
        end
        StFull: begin
          if (pop) begin
            state_q        <= StOne;
            skid_valid_q   <= 1'b0;
            occ_q          <= 2'd1;
            main_payload_q <= skid_payload_q;
            main_target_q  <= skid_target_q;
          end
        end
        default: begin
          state_q      <= StEmpty;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
          occ_q        <= 2'd0;
        end
      endcase
    end
  end

`ifdef MSRV32_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating stall/bubble counters, cleared only by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_valid_q && !m_ready_in && !flush_in && (stall_cnt_q != CntMax)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (!main_valid_q && (bubble_cnt_q != CntMax)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_out  = stall_cnt_q;
  assign bubble_cnt_out = bubble_cnt_q;
`else
  assign stall_cnt_out  = '0;
  assign bubble_cnt_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_pipe_skid_stage.sv
// Self-checking bench for msrv32_pipe_skid_stage. Two instances share all inputs: the default
// build and one with CLEAR_LSB=0, CNT_W=3. Both are compared against a queue-based model.
module tb_msrv32_pipe_skid_stage;

  localparam int unsigned PW = 128;
  localparam int unsigned TW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          flush_in = 1'b0;
  logic          s_valid_in = 1'b0;
  logic [PW-1:0] s_payload_in = '0;
  logic [TW-1:0] s_target_in = '0;
  logic          s_branch_taken_in = 1'b0;
  logic          m_ready_in = 1'b0;

  logic          s_ready_a, s_ready_b;
  logic          m_valid_a, m_valid_b;
  logic [PW-1:0] m_payload_a, m_payload_b;
  logic [TW-1:0] m_target_a, m_target_b;
  logic [1:0]    occ_a, occ_b;
  logic [15:0]   stall_a, bubble_a;
  logic [2:0]    stall_b, bubble_b;

  msrv32_pipe_skid_stage u_dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .flush_in          (flush_in),
    .s_valid_in        (s_valid_in),
    .s_ready_out       (s_ready_a),
    .s_payload_in      (s_payload_in),
    .s_target_in       (s_target_in),
    .s_branch_taken_in (s_branch_taken_in),
    .m_valid_out       (m_valid_a),
    .m_ready_in        (m_ready_in),
    .m_payload_out     (m_payload_a),
    .m_target_out      (m_target_a),
    .occupancy_out     (occ_a),
    .stall_cnt_out     (stall_a),
    .bubble_cnt_out    (bubble_a)
  );

  msrv32_pipe_skid_stage #(
    .CLEAR_LSB (1'b0),
    .CNT_W     (3)
  ) u_dut_nc (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .flush_in          (flush_in),
    .s_valid_in        (s_valid_in),
    .s_ready_out       (s_ready_b),
    .s_payload_in      (s_payload_in),
    .s_target_in       (s_target_in),
    .s_branch_taken_in (s_branch_taken_in),
    .m_valid_out       (m_valid_b),
    .m_ready_in        (m_ready_in),
    .m_payload_out     (m_payload_b),
    .m_target_out      (m_target_b),
    .occupancy_out     (occ_b),
    .stall_cnt_out     (stall_b),
    .bubble_cnt_out    (bubble_b)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [PW-1:0] p;
    logic [TW-1:0] t;
    logic          br;
  } entry_t;

  entry_t q[$];
  int     stall_exp_a, bubble_exp_a, stall_exp_b, bubble_exp_b;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] exp_tgt(input logic [TW-1:0] t, input logic br,
                                            input logic clr);
    logic [TW-1:0] r;
    r = t;
    if (clr && br) r = {t[TW-1:1], 1'b0};
    return r;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Compare all outputs with the model's current contents.
  task automatic check_model();
    int sz;
    sz = q.size();
    check_eq("s_ready_a", s_ready_a, sz < 2);
    check_eq("s_ready_b", s_ready_b, sz < 2);
    check_eq("m_valid_a", m_valid_a, sz > 0);
    check_eq("m_valid_b", m_valid_b, sz > 0);
    check_eq("occ_a", occ_a, sz);
    check_eq("occ_b", occ_b, sz);
    if (sz > 0) begin
      check_eq("payload_a", m_payload_a, q[0].p);
      check_eq("payload_b", m_payload_b, q[0].p);
      check_eq("target_a", m_target_a, exp_tgt(q[0].t, q[0].br, 1'b1));
      check_eq("target_b", m_target_b, exp_tgt(q[0].t, q[0].br, 1'b0));
    end
`ifdef MSRV32_PIPE_PERF_EN
    check_eq("stall_a", stall_a, stall_exp_a);
    check_eq("bubble_a", bubble_a, bubble_exp_a);
    check_eq("stall_b", stall_b, stall_exp_b);
    check_eq("bubble_b", bubble_b, bubble_exp_b);
`else
    check_eq("stall_a", stall_a, 0);
    check_eq("bubble_a", bubble_a, 0);
    check_eq("stall_b", stall_b, 0);
    check_eq("bubble_b", bubble_b, 0);
`endif
  endtask

  // One clock cycle: check, drive, advance model, then sit 1 time unit past the edge.
  task automatic step(input logic v, input logic [PW-1:0] p, input logic [TW-1:0] t,
                      input logic br, input logic rdy, input logic fl);
    logic   acc, pp;
    entry_t e;
    check_model();
    s_valid_in        = v;
    s_payload_in      = p;
    s_target_in       = t;
    s_branch_taken_in = br;
    m_ready_in        = rdy;
    flush_in          = fl;
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && rdy;
    if ((q.size() > 0) && !rdy && !fl) begin
      stall_exp_a = sat_inc(stall_exp_a, 65535);
      stall_exp_b = sat_inc(stall_exp_b, 7);
    end
    if (q.size() == 0) begin
      bubble_exp_a = sat_inc(bubble_exp_a, 65535);
      bubble_exp_b = sat_inc(bubble_exp_b, 7);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.p = p; e.t = t; e.br = br;
        q.push_back(e);
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_in = 1'b1;
    #1;
    check_eq("rst_m_valid", m_valid_a, 1'b0);
    check_eq("rst_occ", occ_a, 2'd0);
    check_eq("rst_s_ready", s_ready_a, 1'b1);
    q.delete();
    stall_exp_a = 0; bubble_exp_a = 0; stall_exp_b = 0; bubble_exp_b = 0;
    s_valid_in = 1'b0; flush_in = 1'b0; m_ready_in = 1'b0; s_branch_taken_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(1'b0);
  endtask

  initial begin
    #2;
    // Bubble counter saturation on the CNT_W=3 instance.
    do_reset();
    for (int i = 0; i < 10; i++) idle(1'b0);
`ifdef MSRV32_PIPE_PERF_EN
    check_eq("bubble_sat_b", bubble_b, 3'd7);
`endif
    // Five stalled cycles with one entry held.
    do_reset();
    step(1'b1, 128'h77, 32'h40, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
`ifdef MSRV32_PIPE_PERF_EN
    check_eq("stall5_a", stall_a, 16'd5);
`endif

    // LSB clear on taken branch, then not-taken.
    do_reset();
    step(1'b1, 128'hA5, 32'h1001, 1'b1, 1'b1, 1'b0);
    check_eq("lsb_valid", m_valid_a, 1'b1);
    check_eq("lsb_occ", occ_a, 2'd1);
    check_eq("lsb_clr_a", m_target_a, 32'h1000);
    check_eq("lsb_noclr_b", m_target_b, 32'h1001);
    step(1'b1, 128'hA5, 32'h1001, 1'b0, 1'b1, 1'b0);
    check_eq("lsb_nt_a", m_target_a, 32'h1001);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back streaming.
    for (int i = 1; i <= 4; i++) step(1'b1, PW'(i), TW'(i * 16), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Back-pressure fills the skid slot; third entry is held off upstream.
    step(1'b1, 128'd1, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 128'd2, 32'h20, 1'b0, 1'b0, 1'b0);
    check_eq("bp_occ", occ_a, 2'd2);
    check_eq("bp_s_ready", s_ready_a, 1'b0);
    step(1'b1, 128'd3, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 128'd3, 32'h30, 1'b0, 1'b1, 1'b0);
    step(1'b1, 128'd3, 32'h30, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush while full, with a new offer in the same cycle.
    step(1'b1, 128'd5, 32'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 128'd6, 32'h60, 1'b0, 1'b0, 1'b0);
    check_eq("fl_pre_occ", occ_a, 2'd2);
    step(1'b1, 128'd9, 32'h90, 1'b0, 1'b0, 1'b1);
    check_eq("fl_m_valid", m_valid_a, 1'b0);
    check_eq("fl_occ", occ_a, 2'd0);
    check_eq("fl_s_ready", s_ready_a, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic with occasional flushes and asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 24) == 0));
      end
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msrv32_pipe_skid_stage.md
Name: msrv32_pipe_skid_stage

Overview:
- Parametrised inter-stage pipeline register for the msrv32 core, generalising the fixed decode-to-execute register.
- Carries an opaque payload bundle plus a 32-bit target address field, with valid/ready flow control on both sides.
- A 2-entry skid buffer allows full throughput while supporting stall back-pressure and synchronous flush (pipeline kill on branch/trap).
- Keeps the branch-target LSB-clear rule on the target field.

Parameters:
PAYLOAD_W, 128, width of opaque control/data bundle (rd_addr, csr_addr, rs1, rs2, imm, opcodes, enables, ...)
TGT_W, 32, width of target/iadder field
CLEAR_LSB, 1, 1 = force target bit 0 to 0 when branch_taken; 0 = pass target unmodified
CNT_W, 16, width of performance counters (used only with MSRV32_PIPE_PERF_EN)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-high
flush_in  input  1  synchronous kill of all held entries
s_valid_in  input  1  upstream entry valid
s_ready_out  output  1  stage can accept; equals NOT skid_valid
s_payload_in  input  PAYLOAD_W  upstream bundle
s_target_in  input  TGT_W  upstream target/iadder value
s_branch_taken_in  input  1  qualifies LSB clear of s_target_in
m_valid_out  output  1  downstream entry valid
m_ready_in  input  1  downstream accepts
m_payload_out  output  PAYLOAD_W  held bundle
m_target_out  output  TGT_W  held target
occupancy_out  output  2  entries held: 0, 1 or 2
stall_cnt_out  output  CNT_W  cycles with m_valid_out=1 and m_ready_in=0 (feature-dependent)
bubble_cnt_out  output  CNT_W  cycles with m_valid_out=0 (feature-dependent)

Behaviour:
- Reset: clk_in, rst_in asynchronous, active-high. All registers to 0: main/skid valid, payload, target, counters. m_valid_out=0, occupancy_out=0, s_ready_out=1 (combinational from skid_valid=0).
- Input transform at capture: stored target = {s_target_in[TGT_W-1:1], (CLEAR_LSB & s_branch_taken_in) ? 1'b0 : s_target_in[0]}. Payload is stored unmodified.
- Accept = s_valid_in & s_ready_out. Pop = m_valid_out & m_ready_in.
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- EMPTY: accept -> ONE, main <= input. Latency is 1 cycle from input to output.
- ONE:
  - accept & pop -> ONE, main <= input. Sustains 1 entry per cycle.
  - accept & !pop -> FULL, skid <= input, main held.
  - !accept & pop -> EMPTY.
  - Otherwise hold.
- FULL: s_ready_out=0, so no accept. pop -> ONE, main <= skid. Otherwise hold.
- Ordering is strict FIFO. No entry is duplicated or dropped except on flush.
- flush_in has the highest priority: next state EMPTY, both valids cleared. An entry offered in the same cycle counts as accepted upstream but is discarded. A pop in the same cycle still completes downstream. Payload/target data registers are not cleared.
- m_payload_out and m_target_out are driven directly from the main register; their value is don't-care when m_valid_out=0.
- All outputs are glitch-free registered values except s_ready_out.
- rst_in asserted mid-transfer: everything is cleared immediately and no output is produced for in-flight entries.

Optional Feature:
- Macro: MSRV32_PIPE_PERF_EN.
- Defined:
  - stall_cnt_out increments each cycle with m_valid_out & !m_ready_in & !flush_in.
  - bubble_cnt_out increments each cycle with !m_valid_out.
  - Both counters saturate at 2^CNT_W-1 and are cleared only by rst_in.
- Undefined: both ports remain present and are tied to 0. No counter logic is synthesised.

Test Plan:
- Reset then s_valid_in=1 with payload 0xA5, target 0x1001, branch_taken=1, m_ready_in=1 -> next cycle m_valid_out=1, m_target_out=0x1000, occupancy_out=1.
- Same as above with branch_taken=0 -> m_target_out=0x1001. With CLEAR_LSB=0 and branch_taken=1 -> m_target_out=0x1001.
- Stream 1,2,3,4 back-to-back with m_ready_in=1 -> outputs 1,2,3,4 on consecutive cycles, s_ready_out stays 1.
- Send 1,2,3 while m_ready_in=0 -> after 2 is accepted, occupancy_out=2 and s_ready_out=0, and 3 is held off upstream. Raise m_ready_in -> outputs 1,2,3 in order, none lost.
- With occupancy_out=2, assert flush_in plus s_valid_in carrying 9 -> next cycle m_valid_out=0, occupancy_out=0, s_ready_out=1, and 9 never appears.
- With MSRV32_PIPE_PERF_EN: hold m_valid_out=1 with m_ready_in=0 for 5 cycles -> stall_cnt_out=5. Set CNT_W=3 and run 10 idle cycles -> bubble_cnt_out saturates at 7.
